// File: rtl/lif_neuron_tile.sv
// Tile of size_tile leaky integrate-and-fire neurons: parallel weight accumulation, serial
// integrate/leak/threshold sweep, spike vector on valid/ready. Optional macro: LIF_LEAK_EN.
module lif_neuron_tile #(
    parameter int size_data = 8,
    parameter int size_vmem = 16,
    parameter int size_tile = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [size_data*size_tile-1:0] in_weight,
    input  logic                           block_done,
    input  logic                           update,
    input  logic signed [size_vmem-1:0]    threshold,
    input  logic signed [size_vmem-1:0]    leak,
    input  logic                           reset_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [size_tile-1:0]           out_spike,
    output logic                           busy,
    output logic [1:0]                     state_dbg
);

    localparam int idx_w = $clog2(size_tile);
    localparam logic [idx_w-1:0] last_idx = idx_w'(size_tile - 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SWEEP = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [size_vmem-1:0] acc  [size_tile];
    logic signed [size_vmem-1:0] vmem [size_tile];
    logic signed [size_vmem-1:0] wext [size_tile];
    logic [idx_w-1:0]            idx;
    logic                        upd_q;
    logic                        mode_q;
    logic signed [size_vmem-1:0] thr_q;
    logic signed [size_vmem-1:0] v_int;
    logic signed [size_vmem-1:0] v_lk;
    logic signed [size_vmem-1:0] v_new;
    logic                        fire;

    function automatic logic signed [size_vmem-1:0] sat_fit(input logic [size_vmem:0] s);
        if (s[size_vmem] != s[size_vmem-1])
            return s[size_vmem] ? {1'b1, {(size_vmem-1){1'b0}}} : {1'b0, {(size_vmem-1){1'b1}}};
        return s[size_vmem-1:0];
    endfunction

    function automatic logic signed [size_vmem-1:0] sat_add(input logic signed [size_vmem-1:0] a,
                                                            input logic signed [size_vmem-1:0] b);
        return sat_fit({a[size_vmem-1], a} + {b[size_vmem-1], b});
    endfunction

    function automatic logic signed [size_vmem-1:0] sat_sub(input logic signed [size_vmem-1:0] a,
                                                            input logic signed [size_vmem-1:0] b);
        return sat_fit({a[size_vmem-1], a} - {b[size_vmem-1], b});
    endfunction

    always_comb begin
        for (int n = 0; n < size_tile; n++) begin
            wext[n] = {{(size_vmem-size_data){in_weight[n*size_data+size_data-1]}},
                       in_weight[n*size_data +: size_data]};
        end
    end

`ifdef LIF_LEAK_EN
    logic signed [size_vmem-1:0] leak_q;
`else
    logic leak_unused;
    assign leak_unused = ^leak;
`endif

    // Shared sweep datapath for neuron idx; leak and threshold only act in update sweeps.
    always_comb begin
        v_int = sat_add(vmem[idx], acc[idx]);
`ifdef LIF_LEAK_EN
        v_lk = sat_sub(v_int, leak_q);
`else
        v_lk = v_int;
`endif
        fire  = upd_q && (v_lk >= thr_q);
        v_new = v_int;
        if (upd_q) begin
            v_new = v_lk;
            if (fire) v_new = mode_q ? sat_sub(v_lk, thr_q) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in ACCUM, out_valid only in STORE, and out_spike is stable while
    // out_valid waits for out_ready.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (block_done) state_next = SWEEP;
            SWEEP: if (idx == last_idx) state_next = upd_q ? STORE : ACCUM;
            STORE: if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == STORE);
    assign busy      = (state != ACCUM);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < size_tile; n++) begin
                acc[n]  <= '0;
                vmem[n] <= '0;
            end
            idx       <= '0;
            upd_q     <= 1'b0;
            mode_q    <= 1'b0;
            thr_q     <= '0;
            out_spike <= '0;
`ifdef LIF_LEAK_EN
            leak_q    <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        for (int n = 0; n < size_tile; n++) acc[n] <= sat_add(acc[n], wext[n]);
                    end
                    if (block_done) begin
                        upd_q  <= update;
                        mode_q <= reset_mode;
                        thr_q  <= threshold;
`ifdef LIF_LEAK_EN
                        leak_q <= leak;
`endif
                        idx    <= '0;
                    end
                end
                SWEEP: begin
                    vmem[idx] <= v_new;
                    acc[idx]  <= '0;
                    // Integrate-only sweeps leave the previous spike vector untouched.
                    if (upd_q) out_spike[idx] <= fire;
                    idx <= (idx == last_idx) ? '0 : idx + idx_w'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_tile.sv
// Scoreboard bench for lif_neuron_tile: spec-level neuron model pushes expected spike vectors,
// a negedge monitor pops and compares them on each output handshake.
module tb_lif_neuron_tile;

  localparam int DW = 8;
  localparam int VW = 16;
  localparam int T  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW*T-1:0] in_weight;
  logic            block_done;
  logic            update;
  logic [VW-1:0]   threshold;
  logic [VW-1:0]   leak;
  logic            reset_mode;
  logic            out_valid;
  logic            out_ready;
  logic [T-1:0]    out_spike;
  logic            busy;
  logic [1:0]      state_dbg;

  lif_neuron_tile #(.size_data(DW), .size_vmem(VW), .size_tile(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .block_done(block_done), .update(update),
    .threshold(threshold), .leak(leak), .reset_mode(reset_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_spike(out_spike),
    .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [T-1:0] exp_q[$];
  int acc_m[T];
  int vmem_m[T];
  int vec[T];
  logic [T-1:0] last_spike;
  int nv, wv, upd_r, thr_r, lk_r, mode_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int sat(input int x);
    int lo = -(1 << (VW-1));
    int hi = (1 << (VW-1)) - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Reference model: one block of the neuron rules applied to whole arrays at once.
  task automatic model_accept();
    for (int n = 0; n < T; n++) acc_m[n] = sat(acc_m[n] + vec[n]);
  endtask

  task automatic model_sweep(input bit upd, input int thr, input int lk, input bit mode);
    logic [T-1:0] spk = '0;
    for (int n = 0; n < T; n++) begin
      int v = sat(vmem_m[n] + acc_m[n]);
      acc_m[n] = 0;
      if (upd) begin
`ifdef LIF_LEAK_EN
        v = sat(v - lk);
`endif
        if (v >= thr) begin
          spk[n] = 1'b1;
          v = mode ? sat(v - thr) : 0;
        end
      end
      vmem_m[n] = v;
    end
    if (upd) exp_q.push_back(spk);
  endtask

  task automatic model_clear();
    for (int n = 0; n < T; n++) begin
      acc_m[n]  = 0;
      vmem_m[n] = 0;
    end
    exp_q.delete();
  endtask

  task automatic pack_vec();
    for (int n = 0; n < T; n++) in_weight[n*DW +: DW] = vec[n][DW-1:0];
  endtask

  task automatic rand_vec();
    for (int n = 0; n < T; n++) vec[n] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    block_done = 1'b0;
    out_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_vec();
    check("in_ready_accum", in_ready, 1);
    pack_vec();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_accept();
  endtask

  task automatic issue_block(input bit with_vec, input bit upd, input int thr, input int lk,
                             input bit mode);
    check("in_ready_before_block", in_ready, 1);
    if (with_vec) pack_vec();
    in_valid   = with_vec;
    block_done = 1'b1;
    update     = upd;
    threshold  = thr[VW-1:0];
    leak       = lk[VW-1:0];
    reset_mode = mode;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    block_done = 1'b0;
    threshold  = VW'($urandom);
    leak       = VW'($urandom);
    reset_mode = 1'($urandom);
    update     = 1'($urandom);
    if (with_vec) model_accept();
    model_sweep(upd, thr, lk, mode);
  endtask

  task automatic finish_block(input bit upd, input int stall, input bit noise);
    int k;
    logic [T-1:0] e;
    if (upd) begin
      out_ready = (stall == 0);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid && k < 40);
      check("valid_latency", k, T + 1);
      last_spike = out_spike;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q[0] : 'x;
        check("stall_hold", {out_valid, in_ready, out_spike}, {1'b1, 1'b0, e});
      end
      if (stall > 0) begin
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
      end
      @(negedge clk);
      check("accum_after_handshake", {in_ready, out_valid}, 2'b10);
    end else begin
      for (int s = 0; s < T; s++) begin
        @(negedge clk);
        check("sweep_busy", {busy, in_ready}, 2'b10);
        if (noise && s < T - 1) begin
          rand_vec();
          pack_vec();
          in_valid = 1'b1;
          block_done = 1'b1;
        end else begin
          in_valid = 1'b0;
          block_done = 1'b0;
        end
      end
      @(negedge clk);
      check("integrate_only_return", {in_ready, out_valid, busy}, 3'b100);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid got out_valid=1 spike=%b expected no output", out_spike);
      end else if (out_ready) begin
        check("spike_out", out_spike, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b0; in_valid = 1'b0; block_done = 1'b0; update = 1'b0;
    threshold = '0; leak = '0; reset_mode = 1'b0; out_ready = 1'b1; in_weight = '0;
    #1 reset = 1'b1;
    #1 check("reset_outputs", {out_valid, out_spike, busy, in_ready}, {1'b0, 4'b0, 1'b0, 1'b1});
    do_reset();

    vec = '{10, 20, 30, 40};
    send_vec();
    send_vec();
    issue_block(0, 1, 50, 0, 0);
    finish_block(1, 0, 0);
    check("basic_spike", last_spike, 4'b1100);

    do_reset();
    vec = '{10, 20, 30, 40};
    send_vec();
    send_vec();
    issue_block(0, 1, 50, 5, 1);
    finish_block(1, 0, 0);
    check("subtract_spike", last_spike, 4'b1100);

    do_reset();
    vec = '{127, 0, 0, 0};
    repeat (300) send_vec();
    issue_block(0, 0, 0, 0, 0);
    finish_block(0, 0, 0);
    vec = '{0, 0, 0, 0};
    issue_block(1, 1, 32767, 0, 1);
    finish_block(1, 0, 0);
    check("saturated_fire", last_spike, 4'b0001);

    do_reset();
    rand_vec();
    send_vec();
    issue_block(0, 1, 0, 0, 0);
    finish_block(1, 10, 0);

    do_reset();
    vec = '{1, 1, 1, 1};
    issue_block(1, 1, 1, 0, 0);
    finish_block(1, 0, 0);
    check("same_cycle_spike", last_spike, 4'b1111);
    issue_block(0, 0, 0, 0, 0);
    finish_block(0, 0, 1);
    issue_block(0, 1, 1, 0, 0);
    finish_block(1, 0, 0);

    repeat (30) begin
      nv = $urandom_range(0, 4);
      repeat (nv) begin
        rand_vec();
        send_vec();
      end
      rand_vec();
      wv     = $urandom_range(0, 1);
      upd_r  = ($urandom_range(0, 3) != 0);
      thr_r  = int'($urandom_range(0, 300)) - 60;
      lk_r   = int'($urandom_range(0, 23)) - 8;
      mode_r = $urandom_range(0, 1);
      issue_block(wv[0], upd_r[0], thr_r, lk_r, mode_r[0]);
      finish_block(upd_r[0], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    vec = '{50, 60, 70, 80};
    send_vec();
    issue_block(0, 1, -100, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("mid_sweep_reset", {out_valid, out_spike, busy, in_ready}, {1'b0, 4'b0, 1'b0, 1'b1});
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    vec = '{0, 0, 0, 0};
    issue_block(1, 1, 1, 0, 0);
    finish_block(1, 0, 0);
    check("fresh_after_reset", last_spike, 4'b0000);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
